mod_recombine: RTL and testbench

MOD_RECOMBINE -- requirements
Module: mod_recombine

---
 rtl/mod_recombine_if.sv | 64 ++++++
 rtl/mod_recombine.sv | 153 +++++++++++++++
 tb/tb_mod_recombine.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mod_recombine_if.sv
// ---------------------------------------------------------------------------
// mod_recombine_if
//   Handshake and operand bundle for mod_recombine.
//
//   Handshake semantics (both channels):
//     A transfer happens on a rising clk edge where valid=1 and ready=1.
//     The producer holds valid (and its data) until that edge. The consumer
//     may raise or drop ready at will. On the input channel in_ready is the
//     DUT's "idle" flag. On the output channel num/overflow are held stable
//     for as long as out_valid=1.
//
//   Signals:
//     in_valid   master->slave  operand set present
//     in_ready   slave->master  block can accept operands
//     quotient   master->slave  WIDTH-bit quotient operand
//     divider    master->slave  WIDTH-bit divisor operand
//     remainder  master->slave  WIDTH-bit remainder operand
//     out_valid  slave->master  result present
//     out_ready  master->slave  consumer takes result
//     num        slave->master  low WIDTH bits of quotient*divider+remainder
//     overflow   slave->master  full-precision result exceeds 2^WIDTH-1
//     bad_rem    slave->master  remainder >= nonzero divider
//                               (present only with MOD_RECOMBINE_CHECK_EN)
//     state      slave->master  debug view of the controller FSM state
//
//   Optional feature macro: MOD_RECOMBINE_CHECK_EN
// ---------------------------------------------------------------------------
interface mod_recombine_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] divider;
  logic [WIDTH-1:0] remainder;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] num;
  logic             overflow;
  logic [1:0]       state;
`ifdef MOD_RECOMBINE_CHECK_EN
  logic             bad_rem;

  modport master (
    output in_valid, quotient, divider, remainder, out_ready,
    input  in_ready, out_valid, num, overflow, bad_rem, state
  );

  modport slave (
    input  in_valid, quotient, divider, remainder, out_ready,
    output in_ready, out_valid, num, overflow, bad_rem, state
  );
`else
  modport master (
    output in_valid, quotient, divider, remainder, out_ready,
    input  in_ready, out_valid, num, overflow, state
  );

  modport slave (
    input  in_valid, quotient, divider, remainder, out_ready,
    output in_ready, out_valid, num, overflow, state
  );
`endif
endinterface

// File: rtl/mod_recombine.sv
// ---------------------------------------------------------------------------
// mod_recombine
//   Recombines a division result: num = quotient*divider + remainder, using a
//   bit-serial shift-and-add multiplier (one quotient bit per cycle, LSB
//   first) followed by a single remainder-add step. The latency from the
//   accept edge to out_valid is fixed at WIDTH+2 cycles, whatever the
//   operand values.
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-low reset
//     bus   mod_recombine_if.slave (handshake, operands, result, state)
//
//   Parameter:
//     WIDTH operand and result width in bits (default 16)
//
//   Optional feature macro: MOD_RECOMBINE_CHECK_EN
//     When defined, the block also drives bus.bad_rem. It is computed in the
//     ADD step and is set when divider != 0 and remainder >= divider. It is
//     held alongside num and cleared by reset.
//
//   FSM: IDLE -> MUL (WIDTH cycles) -> ADD -> DONE -> IDLE
// ---------------------------------------------------------------------------
module mod_recombine #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  mod_recombine_if.slave bus
);

  // Accumulator is one bit wider than a full product. The maximum
  // q*d + r is 2^(2W) - 2^W, so it never wraps.
  localparam int AW = 2 * WIDTH + 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] r_reg;
  logic [AW-1:0]    acc;
  logic [CW-1:0]    idx;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] num_r;
  logic             overflow_r;

  // Partial product for the current quotient bit: divider shifted by the
  // bit index.
  logic [AW-1:0] d_shift;
  // Final sum once the remainder is added in the ADD step.
  logic [AW-1:0] sum_rem;

  assign d_shift = {{(AW - WIDTH){1'b0}}, d_reg} << idx;
  assign sum_rem = acc + {{(AW - WIDTH){1'b0}}, r_reg};

`ifdef MOD_RECOMBINE_CHECK_EN
  logic bad_rem_r;
  logic bad_rem_next;

  assign bad_rem_next = (d_reg != '0) && (r_reg >= d_reg);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      acc         <= '0;
      idx         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      num_r       <= '0;
      overflow_r  <= 1'b0;
`ifdef MOD_RECOMBINE_CHECK_EN
      bad_rem_r   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // in_ready_r is always 1 in IDLE, so in_valid alone marks an accept.
          if (bus.in_valid) begin
            q_reg      <= bus.quotient;
            d_reg      <= bus.divider;
            r_reg      <= bus.remainder;
            acc        <= '0;
            idx        <= '0;
            in_ready_r <= 1'b0;
            state      <= MUL;
          end
        end

        MUL: begin
          if (q_reg[idx]) begin
            acc <= acc + d_shift;
          end
          if (idx == LAST_IDX) begin
            state <= ADD;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        ADD: begin
          acc        <= sum_rem;
          num_r      <= sum_rem[WIDTH-1:0];
          overflow_r <= |sum_rem[AW-1:WIDTH];
`ifdef MOD_RECOMBINE_CHECK_EN
          bad_rem_r  <= bad_rem_next;
`endif
          state      <= DONE;
        end

        DONE: begin
          // The first DONE cycle lets the freshly loaded result settle in its
          // output registers. out_valid rises on the following edge. This
          // gives the fixed WIDTH+2 latency, and the exit below can never
          // fire before the consumer has seen out_valid.
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.num       = num_r;
  assign bus.overflow  = overflow_r;
  assign bus.state     = state;
`ifdef MOD_RECOMBINE_CHECK_EN
  assign bus.bad_rem   = bad_rem_r;
`endif

endmodule

// File: tb/tb_mod_recombine.sv
// ---------------------------------------------------------------------------
// tb_mod_recombine
//   Self-checking bench for mod_recombine (WIDTH=16). Expected results come
//   from an arithmetic model and are pushed to exp_q at accept. They are
//   popped and compared when out_valid appears. Directed cases cover the
//   basic recombine, overflow, a zero divider, back-pressure with operand
//   toggling, reset during MUL, and bad_rem (when MOD_RECOMBINE_CHECK_EN is
//   defined). A few random operand sets follow.
// ---------------------------------------------------------------------------
module tb_mod_recombine;

  localparam int W = 16;
  localparam int TIMEOUT = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  mod_recombine_if #(.WIDTH(W)) bus ();

  mod_recombine #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard ----------------
  // Packing: {bad_rem, overflow, num}
  logic [W+1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] q, input logic [W-1:0] d,
                                        input logic [W-1:0] r);
    longint unsigned full;
    logic            ovf;
    logic            bad;
    full = longint'(q) * longint'(d) + longint'(r);
    ovf  = (full >> W) != 0;
    bad  = (d != 0) && (r >= d);
    return {bad, ovf, full[W-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // Presents an operand set and returns just after the accept edge. The
  // operand inputs are then scribbled, because the DUT must ignore them.
  task automatic send(input logic [W-1:0] q, input logic [W-1:0] d, input logic [W-1:0] r);
    int n;
    n = 0;
    while (!bus.in_ready && n < TIMEOUT) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= TIMEOUT) check("in_ready_timeout", 0, 1);
    bus.quotient  = q;
    bus.divider   = d;
    bus.remainder = r;
    bus.in_valid  = 1'b1;
    exp_q.push_back(model(q, d, r));
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.quotient  = W'($urandom_range(0, 65535));
    bus.divider   = W'($urandom_range(0, 65535));
    bus.remainder = W'($urandom_range(0, 65535));
    check("in_ready_after_accept", bus.in_ready, 0);
  endtask

  // Waits for the result, checks latency and value, and optionally holds
  // out_ready low for `hold` cycles. Call it right after send().
  task automatic collect(input int hold);
    int n;
    logic got;
    logic [W+1:0] exp;
    n   = 0;
    got = 1'b0;
    bus.out_ready = (hold == 0);
    while (!got && n < TIMEOUT) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.out_valid) got = 1'b1;
    end
    check("latency", n, W + 2);
    if (exp_q.size() == 0) begin
      check("queue_underflow", 1, 0);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    if (!got) return;
    check("num", bus.num, exp[W-1:0]);
    check("overflow", bus.overflow, exp[W]);
`ifdef MOD_RECOMBINE_CHECK_EN
    check("bad_rem", bus.bad_rem, exp[W+1]);
`endif
    for (int i = 0; i < hold; i++) begin
      bus.in_valid  = 1'b1;
      bus.quotient  = W'($urandom_range(0, 65535));
      bus.divider   = W'($urandom_range(0, 65535));
      bus.remainder = W'($urandom_range(0, 65535));
      @(posedge clk);
      #1;
      check("hold_out_valid", bus.out_valid, 1);
      check("hold_num", bus.num, exp[W-1:0]);
      check("hold_overflow", bus.overflow, exp[W]);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("out_valid_drop", bus.out_valid, 0);
    check("in_ready_return", bus.in_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.quotient  = '0;
    bus.divider   = '0;
    bus.remainder = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_num", bus.num, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_state", bus.state, 0);

    // Release mid-cycle; the very next rising edge must accept.
    #4 rst = 1'b1;
    send(16'd3, 16'd7, 16'd2);
    collect(0);

    send(16'hFFFF, 16'd2, 16'd1);
    collect(0);

    send(16'd1234, 16'd0, 16'd5);
    collect(0);

    send(16'hFFFF, 16'hFFFF, 16'hFFFF);
    collect(0);

    send(16'd100, 16'd200, 16'd7);
    collect(5);

    // Reset 8 cycles into MUL: outputs drop at once and the op is discarded.
    send(16'hABCD, 16'h1234, 16'h0042);
    repeat (7) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_num", bus.num, 0);
    check("midrst_overflow", bus.overflow, 0);
    check("midrst_state", bus.state, 0);
    exp_q.delete();
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) check("midrst_no_result", bus.out_valid, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    send(16'd2, 16'd2, 16'd0);
    collect(0);

`ifdef MOD_RECOMBINE_CHECK_EN
    send(16'd1, 16'd5, 16'd5);
    collect(0);
    send(16'd1, 16'd5, 16'd4);
    collect(0);
`endif

    for (int i = 0; i < 6; i++) begin
      send(W'($urandom_range(0, 65535)), W'($urandom_range(0, 65535)),
           W'($urandom_range(0, 65535)));
      collect(i % 3);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
